// File: rtl/data_cache_pkg.sv
// Shared types and default sizes for the data-cache tag controller.
package data_cache_pkg;

  localparam int IDX_W_DEF = 4;
  localparam int TAG_W_DEF = 23;

  // Controller modes: post-reset clear, normal service, whole-array invalidate.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // One tag-array word: valid bit above the stored tag.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
  } tag_word_t;

endpackage

// File: rtl/data_cache_tag_ctrl.sv
// Data-cache tag-array controller: clears the array after reset, arbitrates
// invalidate-all / fill / lookup onto a single-port SRAM and returns lookup
// hit/tag one cycle after the read grant.
// Optional macro TAG_CTRL_STARVE_GUARD_EN adds a lookup anti-starvation counter.
module data_cache_tag_ctrl
  import data_cache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_req,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_cmp_tag,
  output logic             lookup_gnt,
  output logic             lookup_rvalid,
  output logic             lookup_hit,
  output logic [TAG_W-1:0] lookup_tag,
  input  logic             fill_req,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  output logic             fill_gnt,
  input  logic             inv_all_req,
  output logic             inv_all_done,
  output logic             init_done,
  output logic             sram_csb0,
  output logic             sram_web0,
  output logic [IDX_W-1:0] sram_addr0,
  output logic [TAG_W:0]   sram_din0,
  input  logic [TAG_W:0]   sram_dout0
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_done_q, init_done_d;
  logic             inv_done_q, inv_done_d;
  logic             rvalid_q, rvalid_d;
  logic [TAG_W-1:0] cmp_tag_q, cmp_tag_d;

  logic             last_idx;
  logic             inv_take;
  logic             starve_pick;

  assign last_idx = (idx_q == {IDX_W{1'b1}});
  // The requester still holds inv_all_req during the done pulse; ignore it then.
  assign inv_take = inv_all_req && !inv_done_q;

`ifdef TAG_CTRL_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;

  assign starve_pick = (state_q == ST_RUN) && !inv_take && fill_req && lookup_req
                       && (starve_q == 2'd3);

  // Count consecutive RUN cycles in which a waiting lookup lost to a fill.
  always_comb begin
    starve_d = 2'd0;
    if (state_q == ST_RUN && !inv_take && fill_req && lookup_req && !starve_pick) begin
      starve_d = (starve_q == 2'd3) ? 2'd3 : starve_q + 2'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starve_pick = 1'b0;
`endif

  // Next-state, arbitration and the single SRAM access for this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    inv_done_d  = 1'b0;
    rvalid_d    = 1'b0;
    cmp_tag_d   = cmp_tag_q;
    lookup_gnt  = 1'b0;
    fill_gnt    = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_addr0  = '0;
    sram_din0   = '0;

    case (state_q)
      ST_INIT, ST_FLUSH: begin
        sram_csb0 = 1'b0;
        sram_web0 = 1'b0;
        sram_addr0 = idx_q;
        idx_d = idx_q + 1'b1;
        if (last_idx) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
          inv_done_d  = (state_q == ST_FLUSH);
        end
      end
      ST_RUN: begin
        if (inv_take) begin
          state_d = ST_FLUSH;
          idx_d   = '0;
        end else if (fill_req && !starve_pick) begin
          fill_gnt   = 1'b1;
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = fill_idx;
          sram_din0  = {1'b1, fill_tag};
        end else if (lookup_req) begin
          lookup_gnt = 1'b1;
          sram_csb0  = 1'b0;
          sram_addr0 = lookup_idx;
          rvalid_d   = 1'b1;
          cmp_tag_d  = lookup_cmp_tag;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // Controller state registers; reset abandons any sweep or pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      inv_done_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      cmp_tag_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      inv_done_q  <= inv_done_d;
      rvalid_q    <= rvalid_d;
      cmp_tag_q   <= cmp_tag_d;
    end
  end

  assign init_done     = init_done_q;
  assign inv_all_done  = inv_done_q;
  assign lookup_rvalid = rvalid_q;
  assign lookup_tag    = rvalid_q ? sram_dout0[TAG_W-1:0] : '0;
  assign lookup_hit    = rvalid_q && sram_dout0[TAG_W]
                         && (sram_dout0[TAG_W-1:0] == cmp_tag_q);

endmodule

// File: tb/tb_data_cache_tag_ctrl.sv
// Directed self-checking bench for data_cache_tag_ctrl with a behavioural
// single-port SRAM (write or registered read on the rising edge).
module tb_data_cache_tag_ctrl;
  import data_cache_pkg::*;

  localparam int IDX_W = 4;
  localparam int TAG_W = 23;
  localparam int SETS  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             lookup_req;
  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_cmp_tag;
  logic             lookup_gnt;
  logic             lookup_rvalid;
  logic             lookup_hit;
  logic [TAG_W-1:0] lookup_tag;
  logic             fill_req;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_gnt;
  logic             inv_all_req;
  logic             inv_all_done;
  logic             init_done;
  logic             sram_csb0;
  logic             sram_web0;
  logic [IDX_W-1:0] sram_addr0;
  logic [TAG_W:0]   sram_din0;
  logic [TAG_W:0]   sram_dout0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_cache_tag_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_req     (lookup_req),
    .lookup_idx     (lookup_idx),
    .lookup_cmp_tag (lookup_cmp_tag),
    .lookup_gnt     (lookup_gnt),
    .lookup_rvalid  (lookup_rvalid),
    .lookup_hit     (lookup_hit),
    .lookup_tag     (lookup_tag),
    .fill_req       (fill_req),
    .fill_idx       (fill_idx),
    .fill_tag       (fill_tag),
    .fill_gnt       (fill_gnt),
    .inv_all_req    (inv_all_req),
    .inv_all_done   (inv_all_done),
    .init_done      (init_done),
    .sram_csb0      (sram_csb0),
    .sram_web0      (sram_web0),
    .sram_addr0     (sram_addr0),
    .sram_din0      (sram_din0),
    .sram_dout0     (sram_dout0)
  );

  // Behavioural SRAM; seeded with valid junk so the clearing sweep is observable.
  logic [TAG_W:0] mem [SETS];
  logic           seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < SETS; i++) mem[i] <= {1'b1, 23'h5A5A00 + 23'(i)};
      seeded <= 1'b1;
    end else if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= mem[sram_addr0];
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance to the next cycle's drive/sample point.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Expect a full clearing sweep starting now; requests held high must not be granted.
  task automatic expect_init_sweep();
    for (int i = 0; i < SETS; i++) begin
      check("sweep_csb", 32'(sram_csb0), 32'd0);
      check("sweep_web", 32'(sram_web0), 32'd0);
      check("sweep_addr", 32'(sram_addr0), 32'(i));
      check("sweep_din", 32'(sram_din0), 32'd0);
      check("sweep_init_done", 32'(init_done), 32'd0);
      check("sweep_lookup_gnt", 32'(lookup_gnt), 32'd0);
      check("sweep_fill_gnt", 32'(fill_gnt), 32'd0);
      @(negedge clk);
      if (i == SETS - 1) begin
        lookup_req = 1'b0;
        fill_req   = 1'b0;
      end
      #1;
    end
    check("init_done_after_sweep", 32'(init_done), 32'd1);
    check("idle_csb_after_sweep", 32'(sram_csb0), 32'd1);
    for (int i = 0; i < SETS; i++) check("mem_cleared", 32'(mem[i]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_init_done"}, 32'(init_done), 32'd0);
    check({name, "_lookup_gnt"}, 32'(lookup_gnt), 32'd0);
    check({name, "_fill_gnt"}, 32'(fill_gnt), 32'd0);
    check({name, "_rvalid"}, 32'(lookup_rvalid), 32'd0);
    check({name, "_hit"}, 32'(lookup_hit), 32'd0);
    check({name, "_tag"}, 32'(lookup_tag), 32'd0);
    check({name, "_inv_done"}, 32'(inv_all_done), 32'd0);
  endtask

  initial begin
    tag_word_t exp_word;
    bit        exp_lgnt;

    rst_n          = 1'b0;
    lookup_req     = 1'b0;
    lookup_idx     = '0;
    lookup_cmp_tag = '0;
    fill_req       = 1'b0;
    fill_idx       = '0;
    fill_tag       = '0;
    inv_all_req    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Reset release: 16 clearing writes, requests ignored, init_done on cycle 17.
    @(negedge clk);
    rst_n      = 1'b1;
    lookup_req = 1'b1;
    fill_req   = 1'b1;
    #1;
    expect_init_sweep();

    // Fill idx 5 tag 0x1234, then lookup of the same index the next cycle.
    @(negedge clk);
    fill_req = 1'b1; fill_idx = 4'd5; fill_tag = 23'h1234;
    #1;
    exp_word.valid = 1'b1;
    exp_word.tag   = 23'h1234;
    check("fill_gnt", 32'(fill_gnt), 32'd1);
    check("fill_web", 32'(sram_web0), 32'd0);
    check("fill_addr", 32'(sram_addr0), 32'd5);
    check("fill_din", 32'(sram_din0), 32'(exp_word));
    @(negedge clk);
    fill_req = 1'b0;
    lookup_req = 1'b1; lookup_idx = 4'd5; lookup_cmp_tag = 23'h1234;
    #1;
    check("lookup_gnt", 32'(lookup_gnt), 32'd1);
    check("lookup_web", 32'(sram_web0), 32'd1);
    check("lookup_addr", 32'(sram_addr0), 32'd5);
    check("lookup_rvalid_early", 32'(lookup_rvalid), 32'd0);
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    check("hit_rvalid", 32'(lookup_rvalid), 32'd1);
    check("hit_hit", 32'(lookup_hit), 32'd1);
    check("hit_tag", 32'(lookup_tag), 32'h1234);
    next_cycle();
    check("rvalid_single", 32'(lookup_rvalid), 32'd0);

    // Same index, different compare tag: valid but miss.
    @(negedge clk);
    lookup_req = 1'b1; lookup_idx = 4'd5; lookup_cmp_tag = 23'h1235;
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    check("tagmiss_hit", 32'(lookup_hit), 32'd0);
    check("tagmiss_tag", 32'(lookup_tag), 32'h1234);

    // Cleared index with a zero compare tag: invalid, so no hit.
    @(negedge clk);
    lookup_req = 1'b1; lookup_idx = 4'd6; lookup_cmp_tag = '0;
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    check("invalid_rvalid", 32'(lookup_rvalid), 32'd1);
    check("invalid_hit", 32'(lookup_hit), 32'd0);

    // Fill and lookup together: fill wins, lookup follows, post-write data returned.
    @(negedge clk);
    fill_req = 1'b1; fill_idx = 4'd15; fill_tag = 23'h7FFFFF;
    lookup_req = 1'b1; lookup_idx = 4'd15; lookup_cmp_tag = 23'h7FFFFF;
    #1;
    check("contend_fill_gnt", 32'(fill_gnt), 32'd1);
    check("contend_lookup_gnt", 32'(lookup_gnt), 32'd0);
    @(negedge clk);
    fill_req = 1'b0;
    #1;
    check("contend_rvalid", 32'(lookup_rvalid), 32'd0);
    check("after_lookup_gnt", 32'(lookup_gnt), 32'd1);
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    check("after_hit", 32'(lookup_hit), 32'd1);
    check("after_tag", 32'(lookup_tag), 32'h7FFFFF);

    // Invalidate-all in RUN with a lookup waiting: nothing granted that cycle.
    @(negedge clk);
    inv_all_req = 1'b1;
    lookup_req = 1'b1; lookup_idx = 4'd5; lookup_cmp_tag = 23'h1234;
    #1;
    check("inv_req_lookup_gnt", 32'(lookup_gnt), 32'd0);
    check("inv_req_csb", 32'(sram_csb0), 32'd1);
    next_cycle();
    for (int i = 0; i < SETS; i++) begin
      check("flush_web", 32'(sram_web0), 32'd0);
      check("flush_addr", 32'(sram_addr0), 32'(i));
      check("flush_din", 32'(sram_din0), 32'd0);
      check("flush_lookup_gnt", 32'(lookup_gnt), 32'd0);
      check("flush_done_early", 32'(inv_all_done), 32'd0);
      next_cycle();
    end
    // Done pulse; the still-held inv_all_req must not restart a flush.
    check("flush_done", 32'(inv_all_done), 32'd1);
    check("flush_init_done", 32'(init_done), 32'd1);
    check("post_flush_lookup_gnt", 32'(lookup_gnt), 32'd1);
    @(negedge clk);
    inv_all_req = 1'b0;
    lookup_req  = 1'b0;
    #1;
    check("flush_done_pulse", 32'(inv_all_done), 32'd0);
    check("post_flush_idle", 32'(sram_csb0), 32'd1);
    check("post_flush_rvalid", 32'(lookup_rvalid), 32'd1);
    check("post_flush_hit", 32'(lookup_hit), 32'd0);
    check("post_flush_tag", 32'(lookup_tag), 32'd0);

    // Continuous fill plus a waiting lookup: guard grants on contended cycles 4 and 8.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      fill_req = 1'b1; fill_idx = 4'd9; fill_tag = 23'(k);
      lookup_req = 1'b1; lookup_idx = 4'd9; lookup_cmp_tag = '0;
      #1;
`ifdef TAG_CTRL_STARVE_GUARD_EN
      exp_lgnt = (k == 4) || (k == 8);
`else
      exp_lgnt = 1'b0;
`endif
      check("starve_lookup_gnt", 32'(lookup_gnt), 32'(exp_lgnt));
      check("starve_fill_gnt", 32'(fill_gnt), 32'(!exp_lgnt));
    end
    @(negedge clk);
    fill_req = 1'b0;
    lookup_req = 1'b0;

    // Reset while the flush sweep is writing index 7.
    @(negedge clk);
    inv_all_req = 1'b1;
    next_cycle();
    for (int i = 0; i < 7; i++) next_cycle();
    check("flush7_addr", 32'(sram_addr0), 32'd7);
    check("flush7_web", 32'(sram_web0), 32'd0);
    rst_n = 1'b0;
    inv_all_req = 1'b0;
    #1;
    check_reset_outputs("midflush_reset");
    check("midflush_reset_addr", 32'(sram_addr0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_init_sweep();

    // Earlier fill at idx 5 is gone after the restarted clear.
    @(negedge clk);
    lookup_req = 1'b1; lookup_idx = 4'd5; lookup_cmp_tag = 23'h1234;
    @(negedge clk);
    lookup_req = 1'b0;
    #1;
    check("final_rvalid", 32'(lookup_rvalid), 32'd1);
    check("final_hit", 32'(lookup_hit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
